// File: rtl/spike_pkg.sv
// Shared definitions for the spike decoder and the neighbouring neuron blocks.
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } dec_state_t;

  localparam int ISI_W         = 8;
  localparam int DEFAULT_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/spike_decoder.sv
// Rate/ISI spike decoder: counts spikes over fixed windows and hands each window
// result to a consumer through a valid/ready register, flagging dropped results.
module spike_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike,
  input  logic             rate_ready,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi,
  output logic             overrun
);

  localparam int WIN_W = $clog2(WINDOW);

  dec_state_t       state;
  dec_state_t       next_state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_total;
  logic [ISI_W-1:0] isi_cnt;
  logic             counting;
  logic             win_end;
  logic             transfer;
  logic             spike_seen;

  assign counting  = (state == COUNT) && enable;
  assign win_end   = counting && (win_cnt == WIN_W'(WINDOW - 1));
  assign transfer  = rate_valid && rate_ready;
  // The spike arriving on the last window cycle still belongs to the closing window.
  assign acc_total = (spike && (acc != {CNT_W{1'b1}})) ? acc + CNT_W'(1) : acc;

  sat_counter #(.W(WIN_W)) u_win_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (!counting || win_end),
    .inc   (counting),
    .count (win_cnt)
  );

  sat_counter #(.W(CNT_W)) u_acc (
    .clk   (clk),
    .reset (reset),
    .clear (!counting || win_end),
    .inc   (counting && spike),
    .count (acc)
  );

  sat_counter #(.W(ISI_W)) u_isi_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (!counting || spike),
    .inc   (counting),
    .count (isi_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = COUNT;
      COUNT:   if (!enable) next_state = (rate_valid && !rate_ready) ? HOLD : IDLE;
      HOLD:    if (rate_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A pending result may only be replaced when the consumer takes it in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate       <= '0;
      rate_valid <= 1'b0;
    end else if (win_end && (!rate_valid || rate_ready)) begin
      rate       <= acc_total;
      rate_valid <= 1'b1;
    end else if (transfer) begin
      rate_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (win_end && rate_valid && !rate_ready)
      overrun <= 1'b1;
    else if (clr_overrun)
      overrun <= 1'b0;
  end

  // The first spike of a run only starts the interval measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isi        <= '0;
      spike_seen <= 1'b0;
    end else if (!counting) begin
      spike_seen <= 1'b0;
    end else if (spike) begin
      spike_seen <= 1'b1;
      if (spike_seen)
        isi <= (isi_cnt == {ISI_W{1'b1}}) ? isi_cnt : isi_cnt + ISI_W'(1);
    end
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Self-checking bench for spike_decoder: hand-derived window vectors, corner-case
// sequences and randomized traffic compared against a behavioural model.
module tb_spike_decoder;

  localparam int WINDOW   = 16;
  localparam int CNT_W    = 4;
  localparam int RATE_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             spike;
  logic             rate_ready;
  logic             clr_overrun;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic [7:0]       isi;
  logic             overrun;

  int checks = 0;
  int passes = 0;

  // Behavioural model: window position, raw spike tally and absolute cycle stamps.
  bit m_run, m_hold, m_valid, m_over, m_have_last;
  int m_pos, m_spikes, m_rate, m_isi, m_cyc, m_last;

  typedef struct {
    int period;
    int exp_rate;
    int exp_isi;
  } vec_t;

  vec_t vecs[8];

  spike_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spike       (spike),
    .rate_ready  (rate_ready),
    .clr_overrun (clr_overrun),
    .rate        (rate),
    .rate_valid  (rate_valid),
    .isi         (isi),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected)
      passes++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    m_run = 0; m_hold = 0; m_valid = 0; m_over = 0; m_have_last = 0;
    m_pos = 0; m_spikes = 0; m_rate = 0; m_isi = 0; m_cyc = 0; m_last = 0;
  endtask

  task automatic modelStep(input bit en, input bit sp, input bit rdy, input bit clr);
    bit xfer;
    bit drop;
    xfer = m_valid && rdy;
    drop = 0;
    if (m_run && en) begin
      if (sp) begin
        if (m_have_last)
          m_isi = (m_cyc - m_last > 255) ? 255 : m_cyc - m_last;
        m_last      = m_cyc;
        m_have_last = 1;
      end
      m_spikes += int'(sp);
      if (m_pos == WINDOW - 1) begin
        if (!m_valid || rdy) begin
          m_rate  = (m_spikes > RATE_MAX) ? RATE_MAX : m_spikes;
          m_valid = 1;
        end else begin
          drop = 1;
        end
        m_pos    = 0;
        m_spikes = 0;
      end else begin
        m_pos++;
        if (xfer) m_valid = 0;
      end
    end else if (m_run) begin
      m_run = 0;
      if (m_valid && !rdy) m_hold = 1;
      else m_valid = 0;
    end else if (m_hold) begin
      if (xfer) begin
        m_valid = 0;
        m_hold  = 0;
      end
    end else if (en) begin
      m_run       = 1;
      m_pos       = 0;
      m_spikes    = 0;
      m_have_last = 0;
    end
    if (drop) m_over = 1;
    else if (clr) m_over = 0;
    m_cyc++;
  endtask

  task automatic applyStimulus(input bit en, input bit sp, input bit rdy, input bit clr);
    enable      = en;
    spike       = sp;
    rate_ready  = rdy;
    clr_overrun = clr;
    @(posedge clk);
    modelStep(en, sp, rdy, clr);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_rate"},    rate,       m_rate);
    check({tag, "_valid"},   rate_valid, int'(m_valid));
    check({tag, "_isi"},     isi,        m_isi);
    check({tag, "_overrun"}, overrun,    int'(m_over));
  endtask

  task automatic doReset();
    reset = 1; enable = 0; spike = 0; rate_ready = 0; clr_overrun = 0;
    modelReset();
    #1;
    check("reset_rate", rate, 0);
    check("reset_valid", rate_valid, 0);
    check("reset_isi", isi, 0);
    check("reset_overrun", overrun, 0);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    int p;
    int rdy_pct;

    vecs[0] = '{4, 4, 4};
    vecs[1] = '{1, 15, 1};
    vecs[2] = '{3, 6, 3};
    vecs[3] = '{5, 4, 5};
    vecs[4] = '{16, 1, 0};
    vecs[5] = '{7, 3, 7};
    vecs[6] = '{2, 8, 2};
    vecs[7] = '{0, 0, 0};

    // One full window per vector, spiking on window cycles that are multiples of the period.
    for (int v = 0; v < 8; v++) begin
      p = vecs[v].period;
      doReset();
      applyStimulus(1, 0, 1, 0);
      for (int k = 0; k < WINDOW; k++) begin
        applyStimulus(1, (p == 0) ? 1'b0 : ((k % p) == 0), 1, 0);
        checkOutput("tbl");
      end
      check("tbl_exp_valid", rate_valid, 1);
      check("tbl_exp_rate", rate, vecs[v].exp_rate);
      check("tbl_exp_isi", isi, vecs[v].exp_isi);
      applyStimulus(1, p != 0, 1, 0);
      check("tbl_valid_pulse", rate_valid, 0);
    end

    doReset();
    applyStimulus(1, 0, 1, 0);
    for (int k = 0; k < 2 * WINDOW; k++) begin
      applyStimulus(1, 1, 1, 0);
      checkOutput("sat");
      if (k == WINDOW - 1 || k == 2 * WINDOW - 1) check("sat_rate", rate, 15);
    end

    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < WINDOW; k++) applyStimulus(1, k < 2, 0, 0);
    check("ov_first_rate", rate, 2);
    check("ov_first_valid", rate_valid, 1);
    check("ov_not_yet", overrun, 0);
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus(1, k < 5, 0, 0);
      checkOutput("ov");
    end
    check("ov_held_rate", rate, 2);
    check("ov_held_valid", rate_valid, 1);
    check("ov_set", overrun, 1);
    applyStimulus(1, 0, 0, 1);
    check("ov_cleared", overrun, 0);

    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < WINDOW; k++) applyStimulus(1, k < 3, 0, 0);
    check("b2b_first_rate", rate, 3);
    for (int k = 0; k < WINDOW; k++) begin
      applyStimulus(1, k == WINDOW - 1, k == WINDOW - 1, 0);
      if (k == WINDOW - 2) check("b2b_held_valid", rate_valid, 1);
    end
    check("b2b_rate", rate, 1);
    check("b2b_valid", rate_valid, 1);
    check("b2b_overrun", overrun, 0);

    doReset();
    applyStimulus(1, 0, 1, 0);
    for (int k = 0; k < 7; k++) applyStimulus(1, (k % 2 == 0) && (k < 6), 1, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 1, 0);
      checkOutput("drop");
    end
    check("drop_no_valid", rate_valid, 0);
    applyStimulus(1, 0, 1, 0);
    for (int k = 0; k < WINDOW; k++) applyStimulus(1, k == 0, 1, 0);
    check("drop_fresh_rate", rate, 1);
    check("drop_fresh_valid", rate_valid, 1);

    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < WINDOW; k++) applyStimulus(1, k < 4, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("hold");
    end
    check("hold_rate", rate, 4);
    check("hold_valid", rate_valid, 1);
    applyStimulus(0, 0, 1, 0);
    check("hold_released", rate_valid, 0);

    doReset();
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0);
    for (int k = 0; k < 299; k++) applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0);
    check("isi_sat", isi, 255);
    checkOutput("isi_sat");

    // Asynchronous reset lands between clock edges while a result is pending.
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < WINDOW; k++) applyStimulus(1, k < 2, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 1, 0, 0);
    check("async_pre_valid", rate_valid, 1);
    #2;
    reset = 1;
    modelReset();
    #1;
    check("async_rate", rate, 0);
    check("async_valid", rate_valid, 0);
    check("async_isi", isi, 0);
    check("async_overrun", overrun, 0);
    @(posedge clk);
    #1;
    reset = 0;

    rdy_pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(5, 95);
      applyStimulus($urandom_range(0, 99) < 96, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 5);
      checkOutput("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
